int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_int_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl
//
// Eight-source edge-triggered interrupt controller for a small 8-bit CPU.
// Each peripheral request line is edge-detected and latched in a pending
// register. A mask register selects which pending sources may interrupt
// the CPU. A three-state handshake FSM (IDLE -> ASSERT -> SERVICE) drives
// the CPU interrupt line:
//   - the CPU acknowledges with interrupt_ack;
//   - the handler signals end-of-interrupt by writing the pending register.
// Both registers are reachable through the CPU port bus.
//
// Build option:
//   INT_CTRL_SYNC_EN - when defined, irq_in passes through a 2-flop
//                      synchroniser before edge detection, which adds two
//                      clocks of latency. Leave it undefined when the
//                      request lines are already in the clk domain.
//
// Parameters:
//   ADDR_PEND     port address of the pending register
//                 (read; write-1-to-clear; any write is end-of-interrupt)
//   ADDR_MASK     port address of the mask register (read/write, 1 = enabled)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   address       CPU port address
//   value_in      CPU write data
//   wen           CPU write strobe
//   ren           CPU read strobe (reads are address-driven, so unused)
//   port_out      registered read data, valid one clock after the address
//   irq_in        peripheral interrupt requests, rising-edge sensitive
//   interrupt     interrupt request to the CPU (high only in ASSERT)
//   interrupt_ack CPU acknowledge pulse
// ---------------------------------------------------------------------------
module int_ctrl #(
   parameter logic [7:0] ADDR_PEND = 8'hF0,
   parameter logic [7:0] ADDR_MASK = 8'hF1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] address,
   input  logic [7:0] value_in,
   input  logic       wen,
   input  logic       ren,
   output logic [7:0] port_out,
   input  logic [7:0] irq_in,
   output logic       interrupt,
   input  logic       interrupt_ack
);

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      SERVICE
   } state_t;

   state_t     state;
   logic [7:0] pending;
   logic [7:0] mask;
   logic [7:0] irq_d;
   logic [7:0] irq_cur;
   logic [7:0] irq_edge;
   logic [7:0] pend_clear;
   logic       pend_wr;
   logic       mask_wr;
   logic       unused_ren;

   // The read strobe carries no information for this block because reads
   // are selected purely by address; it is kept on the port list so the
   // block drops straight into the standard CPU port bus.
   assign unused_ren = ren;

`ifdef INT_CTRL_SYNC_EN
   logic [7:0] irq_sync1;
   logic [7:0] irq_sync2;

   // Two-flop synchroniser for request lines from another clock domain.
   // Edge detection looks only at the second stage, so a metastable first
   // stage never reaches the pending logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_sync1 <= 8'h00;
         irq_sync2 <= 8'h00;
      end else begin
         irq_sync1 <= irq_in;
         irq_sync2 <= irq_sync1;
      end
   end

   assign irq_cur = irq_sync2;
`else
   assign irq_cur = irq_in;
`endif

   // Remember last cycle's request levels so that a rising edge can be
   // detected. Because this clears to zero on reset, a line held high
   // through reset release counts as exactly one fresh edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_d <= 8'h00;
      end else begin
         irq_d <= irq_cur;
      end
   end

   // Decode the CPU bus. A pending write both clears bits and acts as the
   // end-of-interrupt marker for the FSM, whatever data it carries.
   always_comb begin
      irq_edge   = irq_cur & ~irq_d;
      pend_wr    = wen && (address == ADDR_PEND);
      mask_wr    = wen && (address == ADDR_MASK);
      pend_clear = pend_wr ? value_in : 8'h00;
   end

   // Pending bits latch every edge regardless of mask, so a masked source
   // is not lost and fires as soon as it is enabled. The set term is OR-ed
   // in after the clear so that an edge arriving in the same cycle as the
   // software clear survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 8'h00;
      end else begin
         pending <= (pending & ~pend_clear) | irq_edge;
      end
   end

   // Mask register, one enable bit per source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask <= 8'h00;
      end else if (mask_wr) begin
         mask <= value_in;
      end
   end

   // Read mux, registered so the CPU sees the data one clock after it
   // presents the address. Unmapped addresses read as zero so this block
   // can be OR-ed into a shared input mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         port_out <= 8'h00;
      end else if (address == ADDR_PEND) begin
         port_out <= pending;
      end else if (address == ADDR_MASK) begin
         port_out <= mask;
      end else begin
         port_out <= 8'h00;
      end
   end

   // Handshake FSM. The interrupt line is a register that is set on entry
   // to ASSERT and cleared on leaving it, so it is glitch-free and equals
   // (state == ASSERT) at all times. Once asserted it is held until the
   // CPU acknowledges, even if software masks every source meanwhile;
   // otherwise the CPU could miss a request it has already begun to take.
   // After the acknowledge the FSM waits in SERVICE for end-of-interrupt;
   // any edges that arrive in the meantime are left in pending and are
   // picked up on the next pass through IDLE. The reset branch clears the
   // line asynchronously, so it drops without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         interrupt <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|(pending & mask)) begin
                  state     <= ASSERT;
                  interrupt <= 1'b1;
               end
            end
            ASSERT: begin
               if (interrupt_ack) begin
                  state     <= SERVICE;
                  interrupt <= 1'b0;
               end
            end
            SERVICE: begin
               if (pend_wr) begin
                  state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               interrupt <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_ctrl
//
// Directed self-checking bench for int_ctrl. Inputs change and outputs are
// sampled at the falling clock edge, so every rising edge sees stable
// inputs. LAT is the extra input latency that the optional synchroniser
// adds; all waits below are written relative to it.
// ---------------------------------------------------------------------------
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   localparam logic [7:0] PEND = 8'hF0;
   localparam logic [7:0] MSK  = 8'hF1;

   logic       clk;
   logic       rst;
   logic [7:0] address;
   logic [7:0] value_in;
   logic       wen;
   logic       ren;
   logic [7:0] port_out;
   logic [7:0] irq_in;
   logic       interrupt;
   logic       interrupt_ack;

   int checks_total;
   int checks_passed;

   int_ctrl #(
      .ADDR_PEND(PEND),
      .ADDR_MASK(MSK)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .value_in     (value_in),
      .wen          (wen),
      .ren          (ren),
      .port_out     (port_out),
      .irq_in       (irq_in),
      .interrupt    (interrupt),
      .interrupt_ack(interrupt_ack)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Wait for n falling edges; each one is one full rising edge later.
   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
      end
   endtask

   // Drive the CPU bus for the coming rising edge.
   task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data,
                                input logic we);
      address  = addr;
      value_in = data;
      wen      = we;
   endtask

   // One write cycle, after which the bus returns to a plain read of addr.
   task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
      applyStimulus(addr, data, 1'b1);
      waitCycles(1);
      applyStimulus(addr, 8'h00, 1'b0);
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks_total++;
      assert (observed === expected) checks_passed++;
      else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
   endtask

   // Directed scenario sequence.
   initial begin
      checks_total  = 0;
      checks_passed = 0;
      rst           = 1'b1;
      ren           = 1'b0;
      irq_in        = 8'h00;
      interrupt_ack = 1'b0;
      applyStimulus(8'h00, 8'h00, 1'b0);
      waitCycles(2);
      checkOutput("reset_interrupt", {7'b0, interrupt}, 8'h00);
      checkOutput("reset_port_out", port_out, 8'h00);
      rst = 1'b0;
      waitCycles(1);

      // Basic flow: mask bit 0, pulse irq 0, ack, EOI.
      $display("[TB] basic pulse / ack / EOI");
      busWrite(MSK, 8'h01);
      applyStimulus(PEND, 8'h00, 1'b0);
      irq_in = 8'h01;
      waitCycles(1);
      irq_in = 8'h00;
      if (LAT > 0) begin
         waitCycles(LAT);
      end
      checkOutput("pend_latency", dut.pending, 8'h01);
      checkOutput("irq_not_yet", {7'b0, interrupt}, 8'h00);
      waitCycles(1);
      checkOutput("irq_latency", {7'b0, interrupt}, 8'h01);
      checkOutput("read_pending", port_out, 8'h01);
      interrupt_ack = 1'b1;
      waitCycles(1);
      interrupt_ack = 1'b0;
      checkOutput("ack_drops_irq", {7'b0, interrupt}, 8'h00);
      interrupt_ack = 1'b1;
      waitCycles(1);
      interrupt_ack = 1'b0;
      checkOutput("ack_ignored_service", {7'b0, interrupt}, 8'h00);
      busWrite(PEND, 8'h01);
      waitCycles(1);
      checkOutput("eoi_clears_pend", port_out, 8'h00);
      checkOutput("eoi_idle", {7'b0, interrupt}, 8'h00);

      // Masked source stays pending, then fires one clock after unmasking.
      $display("[TB] masked pending then unmask");
      busWrite(MSK, 8'h00);
      applyStimulus(PEND, 8'h00, 1'b0);
      irq_in = 8'h08;
      waitCycles(1);
      irq_in = 8'h00;
      waitCycles(LAT + 2);
      checkOutput("masked_pending", port_out, 8'h08);
      checkOutput("masked_no_irq", {7'b0, interrupt}, 8'h00);
      busWrite(MSK, 8'h08);
      checkOutput("unmask_same_clk", {7'b0, interrupt}, 8'h00);
      waitCycles(1);
      checkOutput("unmask_irq", {7'b0, interrupt}, 8'h01);
      interrupt_ack = 1'b1;
      waitCycles(1);
      interrupt_ack = 1'b0;
      busWrite(PEND, 8'h08);
      waitCycles(1);
      checkOutput("unmask_eoi_idle", {7'b0, interrupt}, 8'h00);

      // Masking in ASSERT holds the line; an edge during SERVICE re-fires.
      $display("[TB] edge during service, partial EOI");
      busWrite(MSK, 8'h21);
      irq_in = 8'h01;
      waitCycles(1);
      irq_in = 8'h00;
      waitCycles(LAT + 1);
      checkOutput("irq0_assert", {7'b0, interrupt}, 8'h01);
      busWrite(MSK, 8'h00);
      waitCycles(1);
      checkOutput("mask_in_assert_holds", {7'b0, interrupt}, 8'h01);
      interrupt_ack = 1'b1;
      waitCycles(1);
      interrupt_ack = 1'b0;
      checkOutput("ack_after_mask", {7'b0, interrupt}, 8'h00);
      busWrite(MSK, 8'h21);
      irq_in = 8'h20;
      waitCycles(1);
      irq_in = 8'h00;
      waitCycles(LAT + 1);
      checkOutput("service_latches", dut.pending, 8'h21);
      checkOutput("service_no_irq", {7'b0, interrupt}, 8'h00);
      busWrite(PEND, 8'h01);
      waitCycles(1);
      checkOutput("reassert_after_eoi", {7'b0, interrupt}, 8'h01);
      checkOutput("pend_left_bit5", port_out, 8'h20);
      interrupt_ack = 1'b1;
      waitCycles(1);
      interrupt_ack = 1'b0;
      busWrite(PEND, 8'h20);
      waitCycles(1);
      checkOutput("bit5_eoi_idle", {7'b0, interrupt}, 8'h00);

      // Set beats clear when an edge lands on the clearing write.
      $display("[TB] set wins over clear");
      irq_in = 8'h04;
      if (LAT > 0) begin
         waitCycles(LAT);
      end
      busWrite(PEND, 8'h04);
      checkOutput("set_wins", dut.pending, 8'h04);
      irq_in = 8'h00;
      busWrite(PEND, 8'h04);
      checkOutput("clear_after_set", dut.pending, 8'h00);

      // Asynchronous reset from ASSERT, with a request held high across it.
      $display("[TB] reset during ASSERT");
      irq_in = 8'h01;
      waitCycles(1);
      irq_in = 8'h00;
      waitCycles(LAT + 1);
      checkOutput("pre_reset_assert", {7'b0, interrupt}, 8'h01);
      irq_in = 8'h10;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_irq", {7'b0, interrupt}, 8'h00);
      waitCycles(2);
      rst = 1'b0;
      checkOutput("post_reset_port", port_out, 8'h00);
      checkOutput("post_reset_pend", dut.pending, 8'h00);
      applyStimulus(MSK, 8'h00, 1'b0);
      waitCycles(1);
      checkOutput("post_reset_mask", port_out, 8'h00);
      applyStimulus(PEND, 8'h00, 1'b0);
      waitCycles(LAT + 1);
      checkOutput("held_high_one_edge", port_out, 8'h10);
      busWrite(PEND, 8'h10);
      waitCycles(LAT + 2);
      checkOutput("held_high_no_reedge", port_out, 8'h00);
      checkOutput("held_high_no_irq", {7'b0, interrupt}, 8'h00);
      irq_in = 8'h00;

      // Mask readback latency and unmapped address.
      $display("[TB] mask readback");
      busWrite(MSK, 8'hA5);
      waitCycles(1);
      checkOutput("mask_readback", port_out, 8'hA5);
      applyStimulus(8'h00, 8'h00, 1'b0);
      waitCycles(1);
      checkOutput("unmapped_read", port_out, 8'h00);

`ifdef INT_CTRL_SYNC_EN
      // Synchroniser latency: pending at +3 clocks, interrupt at +4.
      $display("[TB] synchroniser latency");
      busWrite(MSK, 8'h80);
      irq_in = 8'h80;
      waitCycles(2);
      checkOutput("sync_pend_not_yet", dut.pending, 8'h00);
      waitCycles(1);
      checkOutput("sync_pend_plus3", dut.pending, 8'h80);
      checkOutput("sync_irq_not_yet", {7'b0, interrupt}, 8'h00);
      waitCycles(1);
      checkOutput("sync_irq_plus4", {7'b0, interrupt}, 8'h01);
      irq_in = 8'h00;
`endif

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
